// File: rtl/riscv_mpsoc_pkg.sv
// Shared AHB-Lite encodings used across the MPSoC interconnect.
package riscv_mpsoc_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;
    localparam logic [2:0] HSIZE_QWORD = 3'b100;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/riscv_ahb2apb.sv
// AHB-Lite slave to APB4 master bridge, same data width on both sides.
// Every AHB beat becomes one independent APB access; errors use the two-cycle AHB response.
module riscv_ahb2apb
    import riscv_mpsoc_pkg::*;
#(
    parameter int PLEN       = 64,
    parameter int XLEN       = 64,
    parameter int PADDR_SIZE = 16
) (
    input  logic                  HRESETn,
    input  logic                  HCLK,
    input  logic                  HSEL,
    input  logic [PLEN-1:0]       HADDR,
    input  logic [XLEN-1:0]       HWDATA,
    output logic [XLEN-1:0]       HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    output logic                  HREADYOUT,
    input  logic                  HREADY,
    output logic                  HRESP,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [2:0]            PPROT,
    output logic                  PWRITE,
    output logic [XLEN/8-1:0]     PSTRB,
    output logic [PADDR_SIZE-1:0] PADDR,
    output logic [XLEN-1:0]       PWDATA,
    input  logic [XLEN-1:0]       PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WDATA, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2
    } state_t;

    localparam int STRBW = XLEN / 8;
    localparam int OFFW  = $clog2(STRBW);

    state_t                state_q, state_d;
    logic                  accept, size_err, can_accept;
    logic [OFFW-1:0]       addr_off;
    logic [STRBW-1:0]      strb_w;
    logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [2:0]            pprot_q, pprot_d;
    logic [STRBW-1:0]      pstrb_q, pstrb_d;
    logic [PADDR_SIZE-1:0] paddr_q, paddr_d;
    logic [XLEN-1:0]       pwdata_q, pwdata_d, hrdata_q, hrdata_d;
    logic                  unused_sig;

    assign unused_sig = ^{HBURST, HMASTLOCK, HPROT[3:2], HADDR[PLEN-1:PADDR_SIZE]};

    assign accept     = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
    assign size_err   = int'(HSIZE) > OFFW;
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign addr_off   = HADDR[OFFW-1:0];

    // A lane is enabled when it sits in the same size-aligned block as the address.
    for (genvar gi = 0; gi < STRBW; gi++) begin : g_strb
        localparam logic [OFFW-1:0] LANE = OFFW'(gi);
        assign strb_w[gi] = ((LANE >> HSIZE) == (addr_off >> HSIZE));
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (accept)        state_d = size_err ? ST_ERR1 : (HWRITE ? ST_WDATA : ST_SETUP);
                else               state_d = ST_IDLE;
            end
            ST_WDATA:              state_d = ST_SETUP;
            ST_SETUP:              state_d = ST_ACCESS;
            ST_ACCESS: if (PREADY) state_d = PSLVERR ? ST_ERR1 : ST_IDLE;
            ST_ERR1:               state_d = ST_ERR2;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_ERR2);
        HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end

    always_comb begin
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pprot_d   = pprot_q;
        pstrb_d   = pstrb_q;
        pwdata_d  = pwdata_q;
        hrdata_d  = hrdata_q;
        if (can_accept && accept && !size_err) begin
            paddr_d  = HADDR[PADDR_SIZE-1:0];
            pwrite_d = HWRITE;
            pprot_d  = {~HPROT[0], 1'b1, HPROT[1]};
            pstrb_d  = HWRITE ? strb_w : '0;
        end
        if (state_q == ST_WDATA) pwdata_d = HWDATA;
        if ((state_q == ST_ACCESS) && PREADY && !PSLVERR) hrdata_d = PRDATA;
        psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d = (state_d == ST_ACCESS);
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pprot_q   <= '0;
            pstrb_q   <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            hrdata_q  <= '0;
        end else begin
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            pprot_q   <= pprot_d;
            pstrb_q   <= pstrb_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            hrdata_q  <= hrdata_d;
        end
    end

    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PPROT   = pprot_q;
    assign PSTRB   = pstrb_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign HRDATA  = hrdata_q;

endmodule

// File: tb/tb_riscv_ahb2apb.sv
// Directed bench for the AHB-to-APB bridge: reset, reads, writes, wait states, errors, back-to-back.
module tb_riscv_ahb2apb;

    logic        HRESETn, HCLK;
    logic        HSEL, HWRITE, HMASTLOCK, HREADY, HREADYOUT, HRESP;
    logic [63:0] HADDR, HWDATA, HRDATA, PWDATA, PRDATA;
    logic [2:0]  HSIZE, HBURST, PPROT;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [7:0]  PSTRB;
    logic [15:0] PADDR;
    int          total = 0;
    int          bad   = 0;

    riscv_ahb2apb #(.PLEN(64), .XLEN(64), .PADDR_SIZE(16)) dut (
        .HRESETn(HRESETn), .HCLK(HCLK), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADYOUT(HREADYOUT), .HREADY(HREADY),
        .HRESP(HRESP), .PSEL(PSEL), .PENABLE(PENABLE), .PPROT(PPROT), .PWRITE(PWRITE),
        .PSTRB(PSTRB), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    assign HREADY = HREADYOUT;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "bench timeout");
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic ahb(input logic [1:0] tr, input logic [63:0] a, input logic wr,
                       input logic [2:0] sz, input logic [3:0] pr);
        HTRANS = tr; HADDR = a; HWRITE = wr; HSIZE = sz; HPROT = pr;
    endtask

    initial begin
        HRESETn = 1'b0; HSEL = 1'b1; HMASTLOCK = 1'b0; HBURST = 3'b000;
        HWDATA = '0; PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
        ahb(2'b00, 64'h0, 1'b0, 3'd0, 4'h0);
        step(); step();
        chk("rst_hreadyout", HREADYOUT, 1); chk("rst_hresp", HRESP, 0);
        chk("rst_psel", PSEL, 0); chk("rst_penable", PENABLE, 0);
        chk("rst_hrdata", HRDATA, 0); chk("rst_pstrb", PSTRB, 0);
        chk("rst_paddr", PADDR, 0); chk("rst_pprot", PPROT, 0);
        HRESETn = 1'b1;
        step();
        $display("txn reset done");

        // Zero-wait read: PSEL at N+1, PENABLE at N+2, data at N+3
        PRDATA = 64'hDEADBEEF_CAFEF00D;
        ahb(2'b10, 64'h0010, 1'b0, 3'd3, 4'b0011);
        step();
        HTRANS = 2'b00;
        chk("rd_setup_psel", PSEL, 1); chk("rd_setup_pen", PENABLE, 0);
        chk("rd_setup_hready", HREADYOUT, 0); chk("rd_paddr", PADDR, 16'h0010);
        chk("rd_pwrite", PWRITE, 0); chk("rd_pstrb", PSTRB, 0); chk("rd_pprot", PPROT, 3'b011);
        step();
        chk("rd_access_psel", PSEL, 1); chk("rd_access_pen", PENABLE, 1);
        chk("rd_access_hready", HREADYOUT, 0);
        step();
        chk("rd_done_hready", HREADYOUT, 1); chk("rd_done_hresp", HRESP, 0);
        chk("rd_hrdata", HRDATA, 64'hDEADBEEF_CAFEF00D); chk("rd_done_psel", PSEL, 0);
        $display("txn read 0x0010 hrdata=%h", HRDATA);

        // Halfword write at byte 6: lanes 6 and 7
        ahb(2'b10, 64'h0006, 1'b1, 3'd1, 4'b0010);
        step();
        HTRANS = 2'b00; HWDATA = 64'h1234;
        chk("wr_wdata_hready", HREADYOUT, 0); chk("wr_wdata_psel", PSEL, 0);
        step();
        chk("wr_setup_psel", PSEL, 1); chk("wr_setup_pen", PENABLE, 0);
        chk("wr_pwrite", PWRITE, 1); chk("wr_pstrb", PSTRB, 8'b1100_0000);
        chk("wr_pwdata", PWDATA, 64'h1234); chk("wr_paddr", PADDR, 16'h0006);
        chk("wr_pprot", PPROT, 3'b111);
        step();
        chk("wr_access_pen", PENABLE, 1);
        step();
        chk("wr_done_hready", HREADYOUT, 1); chk("wr_done_hresp", HRESP, 0);
        chk("wr_hrdata_hold", HRDATA, 64'hDEADBEEF_CAFEF00D);
        $display("txn write 0x0006 pstrb=c0");

        // Read with five wait states
        PREADY = 1'b0; PRDATA = 64'h1111;
        ahb(2'b10, 64'h0020, 1'b0, 3'd2, 4'b0001);
        step();
        HTRANS = 2'b00;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("wait_hready", HREADYOUT, 0); chk("wait_pen", PENABLE, 1);
            step();
        end
        PREADY = 1'b1;
        chk("wait_last_hready", HREADYOUT, 0); chk("wait_last_pen", PENABLE, 1);
        step();
        chk("wait_done_hready", HREADYOUT, 1); chk("wait_hrdata", HRDATA, 64'h1111);
        $display("txn wait-state read 0x0020 hrdata=%h", HRDATA);

        // Write answered with PSLVERR
        PSLVERR = 1'b1;
        ahb(2'b10, 64'h0008, 1'b1, 3'd3, 4'b0000);
        step();
        HTRANS = 2'b00; HWDATA = 64'hABCD;
        step(); step(); step();
        PSLVERR = 1'b0;
        chk("slverr_e1_hresp", HRESP, 1); chk("slverr_e1_hready", HREADYOUT, 0);
        chk("slverr_e1_psel", PSEL, 0);
        step();
        chk("slverr_e2_hresp", HRESP, 1); chk("slverr_e2_hready", HREADYOUT, 1);
        step();
        chk("slverr_idle_hresp", HRESP, 0); chk("slverr_idle_hready", HREADYOUT, 1);
        chk("slverr_hrdata_hold", HRDATA, 64'h1111);
        $display("txn write slverr 0x0008");

        // Oversized transfer is rejected without touching APB
        ahb(2'b10, 64'h0040, 1'b0, 3'd4, 4'b0000);
        step();
        HTRANS = 2'b00;
        chk("size_e1_hresp", HRESP, 1); chk("size_e1_hready", HREADYOUT, 0);
        chk("size_e1_psel", PSEL, 0);
        step();
        chk("size_e2_hresp", HRESP, 1); chk("size_e2_hready", HREADYOUT, 1);
        chk("size_e2_psel", PSEL, 0);
        step();
        chk("size_idle_hresp", HRESP, 0); chk("size_idle_psel", PSEL, 0);
        $display("txn hsize=4 error");

        // Read then SEQ write accepted in the read's completion cycle
        PRDATA = 64'hA5A5;
        ahb(2'b10, 64'h0030, 1'b0, 3'd3, 4'b0000);
        step();
        HTRANS = 2'b00;
        step(); step();
        chk("b2b_rd_hready", HREADYOUT, 1); chk("b2b_rd_hrdata", HRDATA, 64'hA5A5);
        ahb(2'b11, 64'h0038, 1'b1, 3'd3, 4'b0000);
        step();
        HTRANS = 2'b00; HWDATA = 64'h55;
        chk("b2b_wdata_hready", HREADYOUT, 0); chk("b2b_wdata_psel", PSEL, 0);
        step();
        chk("b2b_setup_psel", PSEL, 1); chk("b2b_pwdata", PWDATA, 64'h55);
        chk("b2b_pstrb", PSTRB, 8'hFF); chk("b2b_paddr", PADDR, 16'h0038);
        step(); step();
        chk("b2b_wr_done", HREADYOUT, 1);
        $display("txn back-to-back read 0x0030 / write 0x0038");

        // BUSY gets a zero-wait OKAY
        HTRANS = 2'b01;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("busy_hready", HREADYOUT, 1); chk("busy_psel", PSEL, 0); chk("busy_hresp", HRESP, 0);
        end
        HTRANS = 2'b00;
        $display("txn busy");

        // Reset during ACCESS aborts the transfer
        PREADY = 1'b0; PRDATA = 64'h77;
        ahb(2'b10, 64'h0050, 1'b0, 3'd3, 4'b0000);
        step();
        HTRANS = 2'b00;
        step();
        chk("abort_access_pen", PENABLE, 1);
        HRESETn = 1'b0;
        step();
        chk("abort_psel", PSEL, 0); chk("abort_pen", PENABLE, 0);
        chk("abort_hready", HREADYOUT, 1); chk("abort_hresp", HRESP, 0);
        chk("abort_hrdata", HRDATA, 0);
        HRESETn = 1'b1; PREADY = 1'b1;
        step();
        chk("abort_after_psel", PSEL, 0);
        $display("txn reset during access");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
